// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types for the two-requester Avalon-MM arbiter: requester identity
// used both for the grant and as the read-owner tag.
package avalon_bus_arbiter_pkg;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } bus_owner_t;

    // Requester that the round-robin pointer favours coming out of reset.
    localparam bus_owner_t RR_RESET_OWNER = OWNER_D;

    // The requester that did not win; used to rotate round-robin priority.
    function automatic bus_owner_t other_owner(input bus_owner_t o);
        return (o == OWNER_I) ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/avalon_bus_arbiter_if.sv
// One Avalon-MM port. The host side (command driver) uses the master modport,
// the agent side (command receiver) uses the slave modport.
interface avalon_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic                  waitrequest;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output read, write, address, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, write, address, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_bus_arbiter_tag_fifo.sv
// Small synchronous FIFO holding the owner tag of every outstanding read,
// so returning beats can be steered back to their requester in order.
module avalon_bus_arbiter_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state: pointers and count, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM host port between the instruction-fetch port (I, read
// only) and the data port (D). Round-robin grant, grant held across
// waitrequest stalls, and read responses routed by an in-order owner tag FIFO.
module avalon_bus_arbiter
    import avalon_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_bus_arbiter_if.slave  i_bus,
    avalon_bus_arbiter_if.slave  d_bus,
    avalon_bus_arbiter_if.master m_bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    logic              lock_q, lock_d;
    bus_owner_t        lock_owner_q, lock_owner_d;
    bus_owner_t        rr_q, rr_d;

    bus_owner_t        grant;
    logic              i_req, d_req, g_req, g_read, g_write;
    logic              blocked, issue, accept, push, pop;
    logic              push_tag;
    logic              fifo_full, fifo_empty, fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    logic              cmd_read, cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [BE_W-1:0]   cmd_byteenable;
    logic [DATA_W-1:0] cmd_writedata;
    logic              i_wait, d_wait, i_rdv, d_rdv;
    logic [DATA_W-1:0] rdata;

    // Port I never writes; its write-side signals are deliberately ignored.
    logic unused_i_write_side;
    assign unused_i_write_side = ^{i_bus.write, i_bus.writedata, fifo_count};

    // Grant selection and command qualification (read gate on a full FIFO).
    always_comb begin
        i_req = i_bus.read;
        d_req = d_bus.read | d_bus.write;
        if (lock_q)                grant = lock_owner_q;
        else if (i_req && !d_req)  grant = OWNER_I;
        else if (d_req && !i_req)  grant = OWNER_D;
        else                       grant = rr_q;
        g_req    = (grant == OWNER_I) ? i_req : d_req;
        // A simultaneous D read+write is treated as a write.
        g_write  = (grant == OWNER_D) && d_bus.write;
        g_read   = g_req && !g_write;
        // A pop in the same cycle does not open the gate: full is registered.
        blocked  = g_read && fifo_full;
        issue    = rst && g_req && !blocked;
        accept   = issue && !m_bus.waitrequest;
        push     = accept && g_read;
        push_tag = grant;
        // Beats arriving with no outstanding read are dropped.
        pop      = rst && m_bus.readdatavalid && !fifo_empty;
    end

    // Lock and round-robin next state: lock while stalled, rotate on accept.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        rr_d         = rr_q;
        if (accept) begin
            lock_d = 1'b0;
            rr_d   = other_owner(grant);
        end else if (issue) begin
            lock_d       = 1'b1;
            lock_owner_d = grant;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_I;
            rr_q         <= RR_RESET_OWNER;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            rr_q         <= rr_d;
        end
    end

    // Command mux, stall feedback and response steering; all quiet in reset.
    always_comb begin
        cmd_read       = issue && g_read;
        cmd_write      = issue && g_write;
        cmd_address    = '0;
        cmd_byteenable = '0;
        cmd_writedata  = '0;
        i_wait         = 1'b1;
        d_wait         = 1'b1;
        if (issue) begin
            if (grant == OWNER_I) begin
                cmd_address    = i_bus.address;
                cmd_byteenable = i_bus.byteenable;
            end else begin
                cmd_address    = d_bus.address;
                cmd_byteenable = d_bus.byteenable;
                cmd_writedata  = d_bus.writedata;
            end
        end
        if (rst && !blocked) begin
            if (grant == OWNER_I) i_wait = m_bus.waitrequest;
            else                  d_wait = m_bus.waitrequest;
        end
        rdata = rst ? m_bus.readdata : '0;
        i_rdv = pop && (bus_owner_t'(fifo_head) == OWNER_I);
        d_rdv = pop && (bus_owner_t'(fifo_head) == OWNER_D);
    end

    assign m_bus.read          = cmd_read;
    assign m_bus.write         = cmd_write;
    assign m_bus.address       = cmd_address;
    assign m_bus.byteenable    = cmd_byteenable;
    assign m_bus.writedata     = cmd_writedata;
    assign i_bus.waitrequest   = i_wait;
    assign d_bus.waitrequest   = d_wait;
    assign i_bus.readdata      = rdata;
    assign d_bus.readdata      = rdata;
    assign i_bus.readdatavalid = i_rdv;
    assign d_bus.readdatavalid = d_rdv;

    avalon_bus_arbiter_tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_tag),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_d_read_write_exclusive: assert property (
        @(posedge clk) disable iff (!rst) !(d_bus.read && d_bus.write));
    a_readdatavalid_has_owner: assert property (
        @(posedge clk) disable iff (!rst) !(m_bus.readdatavalid && fifo_empty));
    a_i_port_read_only: assert property (
        @(posedge clk) disable iff (!rst) !i_bus.write);

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed stimulus pushes expected accepted
// commands and read beats into queues; a monitor pops and compares them.
module tb_avalon_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        port;   // 0 = I, 1 = D
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_if();
    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if();
    avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if();

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PENDING(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_bus (i_if),
        .d_bus (d_if),
        .m_bus (m_if)
    );

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input logic port, input logic [31:0] dat);
        rsp_t r;
        r.port = port; r.data = dat;
        rsp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        i_if.read = 1'b0; i_if.write = 1'b0; i_if.address = '0;
        i_if.byteenable = 4'hF; i_if.writedata = '0;
        d_if.read = 1'b0; d_if.write = 1'b0; d_if.address = '0;
        d_if.byteenable = 4'hF; d_if.writedata = '0;
        m_if.waitrequest = 1'b0; m_if.readdata = '0; m_if.readdatavalid = 1'b0;
    endtask

    // Monitor: every accepted command and every routed read beat is matched
    // against the head of its expectation queue.
    cmd_t ec;
    rsp_t er;
    always @(negedge clk) begin
        if (rst) begin
            if ((m_if.read || m_if.write) && !m_if.waitrequest) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {32'h0, m_if.address}, 64'hFFFF_FFFF);
                end else begin
                    ec = cmd_q.pop_front();
                    chk("cmd_kind", {62'h0, m_if.read, m_if.write}, {62'h0, !ec.wr, ec.wr});
                    chk("cmd_addr", m_if.address, ec.addr);
                    chk("cmd_be", m_if.byteenable, 4'hF);
                    if (ec.wr) chk("cmd_wdata", m_if.writedata, ec.wdata);
                end
            end
            if (i_if.readdatavalid || d_if.readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {62'h0, i_if.readdatavalid, d_if.readdatavalid}, 64'h0);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_port", {62'h0, i_if.readdatavalid, d_if.readdatavalid},
                        er.port ? 64'h1 : 64'h2);
                    chk("rsp_data", er.port ? d_if.readdata : i_if.readdata, er.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state with requests and a stray beat present.
        idle();
        i_if.read = 1'b1; i_if.address = 32'h100;
        d_if.read = 1'b1; d_if.address = 32'h200;
        m_if.readdata = 32'h55; m_if.readdatavalid = 1'b1;
        sample();
        chk("rst_m_read", m_if.read, 0);
        chk("rst_m_write", m_if.write, 0);
        chk("rst_m_address", m_if.address, 0);
        chk("rst_i_wait", i_if.waitrequest, 1);
        chk("rst_d_wait", d_if.waitrequest, 1);
        chk("rst_i_rdv", i_if.readdatavalid, 0);
        chk("rst_d_rdv", d_if.readdatavalid, 0);
        chk("rst_i_rdata", i_if.readdata, 0);
        tick();
        idle();
        rst = 1'b1;
        tick();

        // T1: lone I read, data back two cycles later.
        i_if.read = 1'b1; i_if.address = 32'h100;
        push_cmd(0, 32'h100, 0);
        sample();
        chk("t1_i_wait", i_if.waitrequest, 0);
        tick();
        i_if.read = 1'b0;
        sample();
        tick();
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'hDEADBEEF;
        push_rsp(0, 32'hDEADBEEF);
        sample();
        chk("t1_d_rdv", d_if.readdatavalid, 0);
        chk("t1_d_rdata_mirror", d_if.readdata, 32'hDEADBEEF);
        tick();
        m_if.readdatavalid = 1'b0;

        // T2: both read every cycle; D first, then alternate, beats follow.
        for (int k = 0; k < 6; k++) begin
            i_if.read = 1'b1; i_if.address = 32'h10;
            d_if.read = 1'b1; d_if.address = 32'h20;
            push_cmd(0, (k % 2 == 0) ? 32'h20 : 32'h10, 0);
            if (k > 0) begin
                m_if.readdatavalid = 1'b1;
                m_if.readdata = 32'hA000_0000 + 32'(k - 1);
                push_rsp(((k - 1) % 2 == 0) ? 1'b1 : 1'b0, 32'hA000_0000 + 32'(k - 1));
            end
            sample();
            tick();
        end
        i_if.read = 1'b0; d_if.read = 1'b0;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'hA000_0005;
        push_rsp(0, 32'hA000_0005);
        sample();
        tick();
        m_if.readdatavalid = 1'b0;

        // T3: stalled D write holds the bus while I waits.
        d_if.write = 1'b1; d_if.address = 32'h40; d_if.writedata = 32'h12345678;
        i_if.read = 1'b1; i_if.address = 32'h10;
        m_if.waitrequest = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                m_if.waitrequest = 1'b0;
                push_cmd(1, 32'h40, 32'h12345678);
            end
            sample();
            chk("t3_m_write", m_if.write, 1);
            chk("t3_m_address", m_if.address, 32'h40);
            chk("t3_m_writedata", m_if.writedata, 32'h12345678);
            chk("t3_i_wait", i_if.waitrequest, 1);
            chk("t3_d_wait", d_if.waitrequest, (c == 3) ? 1'b0 : 1'b1);
            tick();
        end
        d_if.address = 32'h44; d_if.writedata = 32'h9;
        push_cmd(0, 32'h10, 0);
        sample();
        chk("t3_i_granted", i_if.waitrequest, 0);
        chk("t3_d_waits", d_if.waitrequest, 1);
        tick();
        i_if.read = 1'b0;
        push_cmd(1, 32'h44, 32'h9);
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'hBBBB_0000;
        push_rsp(0, 32'hBBBB_0000);
        sample();
        tick();
        d_if.write = 1'b0; m_if.readdatavalid = 1'b0;

        // T4: memory silent; four reads fill the tag FIFO, fifth is gated.
        d_if.read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_if.address = 32'h200 + 32'(4 * k);
            push_cmd(0, 32'h200 + 32'(4 * k), 0);
            sample();
            tick();
        end
        d_if.address = 32'h210;
        for (int c = 0; c < 2; c++) begin
            sample();
            chk("t4_full_m_read", m_if.read, 0);
            chk("t4_full_d_wait", d_if.waitrequest, 1);
            tick();
        end
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h11;
        push_rsp(1, 32'h11);
        sample();
        chk("t4_pop_still_gated", m_if.read, 0);
        chk("t4_pop_d_wait", d_if.waitrequest, 1);
        tick();
        m_if.readdatavalid = 1'b0;
        push_cmd(0, 32'h210, 0);
        sample();
        chk("t4_fifth_issued", m_if.read, 1);
        tick();
        d_if.read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_if.readdatavalid = 1'b1; m_if.readdata = 32'h21 + 32'(k);
            push_rsp(1, 32'h21 + 32'(k));
            sample();
            tick();
        end
        m_if.readdatavalid = 1'b0;

        // T5: push and pop in the same cycle at two outstanding reads.
        i_if.read = 1'b1; i_if.address = 32'h300;
        push_cmd(0, 32'h300, 0);
        sample();
        tick();
        i_if.read = 1'b0; d_if.read = 1'b1; d_if.address = 32'h304;
        push_cmd(0, 32'h304, 0);
        sample();
        tick();
        d_if.read = 1'b0; i_if.read = 1'b1; i_if.address = 32'h308;
        push_cmd(0, 32'h308, 0);
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h51;
        push_rsp(0, 32'h51);
        sample();
        tick();
        i_if.read = 1'b0;
        m_if.readdata = 32'h52;
        push_rsp(1, 32'h52);
        sample();
        chk("t5_pending", dut.u_tag_fifo.count_o, 2);
        tick();
        m_if.readdata = 32'h53;
        push_rsp(0, 32'h53);
        sample();
        tick();
        m_if.readdatavalid = 1'b0;

        // T6: reset with three reads outstanding and a locked D read.
        d_if.read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_if.address = 32'h400 + 32'(4 * k);
            push_cmd(0, 32'h400 + 32'(4 * k), 0);
            sample();
            tick();
        end
        d_if.address = 32'h40C; m_if.waitrequest = 1'b1;
        sample();
        chk("t6_stalled_read", m_if.read, 1);
        tick();
        i_if.read = 1'b1; i_if.address = 32'h500;
        sample();
        chk("t6_lock_holds_d", m_if.address, 32'h40C);
        chk("t6_lock_i_wait", i_if.waitrequest, 1);
        chk("t6_lock_set", dut.lock_q, 1);
        tick();
        rst = 1'b0;
        d_if.address = 32'h504; m_if.waitrequest = 1'b0;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h77;
        sample();
        chk("t6_rst_m_read", m_if.read, 0);
        chk("t6_rst_m_address", m_if.address, 0);
        chk("t6_rst_i_wait", i_if.waitrequest, 1);
        chk("t6_rst_d_wait", d_if.waitrequest, 1);
        chk("t6_rst_i_rdv", i_if.readdatavalid, 0);
        chk("t6_rst_d_rdv", d_if.readdatavalid, 0);
        chk("t6_rst_fifo_empty", dut.u_tag_fifo.count_o, 0);
        chk("t6_rst_lock_clear", dut.lock_q, 0);
        tick();
        m_if.readdatavalid = 1'b0;
        rst = 1'b1;
        push_cmd(0, 32'h504, 0);
        sample();
        chk("t6_d_favoured", m_if.address, 32'h504);
        tick();
        d_if.read = 1'b0;
        push_cmd(0, 32'h500, 0);
        sample();
        tick();
        i_if.read = 1'b0;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h61;
        push_rsp(1, 32'h61);
        sample();
        tick();
        m_if.readdata = 32'h62;
        push_rsp(0, 32'h62);
        sample();
        tick();
        m_if.readdatavalid = 1'b0;
        sample();
        chk("end_cmd_queue_drained", cmd_q.size(), 0);
        chk("end_rsp_queue_drained", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
Two-requester arbiter that shares one Avalon-MM host port (unified memory) between the CPU instruction fetch port (port I, read-only) and the data port (port D, read/write). It grants one command per cycle with round-robin priority and holds the grant while downstream waitrequest stalls a command. It tracks the owners of outstanding pipelined reads so that each readdatavalid beat is routed back to the correct requester in order. It sits between the Cpu bus hosts and the memory/interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_PENDING, 4, maximum outstanding reads (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
i_read  in  1  port I read request
i_address  in  ADDR_W  port I address
i_byteenable  in  DATA_W/8  port I byte enables
i_waitrequest  out  1  port I stall
i_readdata  out  DATA_W  port I read data
i_readdatavalid  out  1  port I read data valid
d_read  in  1  port D read request
d_write  in  1  port D write request
d_address  in  ADDR_W  port D address
d_byteenable  in  DATA_W/8  port D byte enables
d_writedata  in  DATA_W  port D write data
d_waitrequest  out  1  port D stall
d_readdata  out  DATA_W  port D read data
d_readdatavalid  out  1  port D read data valid
m_read  out  1  downstream read
m_write  out  1  downstream write
m_address  out  ADDR_W  downstream address
m_byteenable  out  DATA_W/8  downstream byte enables
m_writedata  out  DATA_W  downstream write data
m_waitrequest  in  1  downstream stall
m_readdata  in  DATA_W  downstream read data
m_readdatavalid  in  1  downstream read data valid

Behaviour:
- Reset (rst=0, async): lock cleared, tag FIFO empty, pending count 0, round-robin pointer favours D. While in reset, m_read=m_write=0, both *_readdatavalid=0, both *_waitrequest=1, and all data/address outputs are 0.
- A request is active when i_read=1 (I) or d_read|d_write=1 (D). Asserting d_read and d_write together is illegal: an assertion fires, and the arbiter treats it as a write.
- Grant, combinational:
  - If the lock is set, grant = lock_owner.
  - Otherwise, if exactly one request is active, it wins.
  - Otherwise, if both are active, the requester named by the round-robin pointer wins.
- Read gate: a granted read is blocked when pending == MAX_PENDING, even if a pop occurs in the same cycle. While blocked, m_read=0 and the requester sees waitrequest=1.
- Forwarding: the granted, unblocked command drives m_*. Non-granted port waitrequest=1. Granted port waitrequest = m_waitrequest. With no request, m_read=m_write=0.
- Acceptance: the command is accepted when it is issued and m_waitrequest=0.
- Lock: if the command is issued with m_waitrequest=1, set lock with lock_owner=grant. Clear the lock on acceptance. Grant never changes while the lock is set (Avalon command stability).
- Round-robin: on each acceptance, the pointer moves to the non-winning port.
- Read tags: each accepted read pushes its owner tag (0=I, 1=D) into the FIFO. Writes push nothing. pending = FIFO occupancy.
- Response routing: on m_readdatavalid=1, the head tag selects the destination. That port's readdatavalid=1 with readdata=m_readdata, the other port's readdatavalid=0, and the head is popped. readdata on both ports always mirrors m_readdata.
- Push and pop in the same cycle: occupancy unchanged, FIFO order preserved.
- Response latency: 0 cycles (combinational pass-through). Command latency: 0 cycles (combinational mux).
- m_readdatavalid with an empty FIFO is a protocol error: an assertion fires, the beat is dropped, and no port sees valid.
- Pointer wrap: FIFO read/write pointers are log2(MAX_PENDING) bits wide and wrap naturally. The count is one bit wider.

Decomposition:
- Types package: typedef bus_owner_t enum {OWNER_I, OWNER_D}.
- Sub-module tag_fifo: synchronous FIFO with params WIDTH=1 and DEPTH=MAX_PENDING, async active-low reset, push/pop/full/empty/count/head ports.
- The arbiter holds the lock and round-robin registers plus the muxing.

Test Plan:
- Only I reads 0x100, m_waitrequest=0, data returns 0xDEADBEEF after 2 cycles -> m_address=0x100, i_readdatavalid=1 with 0xDEADBEEF, d_readdatavalid=0.
- I and D both read every cycle (I 0x10, D 0x20), zero wait -> m_address alternates 0x20,0x10,0x20,... (D first after reset); responses route back in the same alternating order.
- D write 0x40 with m_waitrequest=1 for 3 cycles while I requests -> m_write, m_address=0x40 and m_writedata held stable 4 cycles; I waitrequest=1 throughout; I granted in the cycle after acceptance.
- Memory never returns data, MAX_PENDING=4 -> exactly 4 reads accepted, 5th held with m_read=0 and waitrequest=1; one m_readdatavalid then allows a 5th acceptance on the following cycle.
- A pop and a new read acceptance in the same cycle at pending=2 -> pending stays 2, and the tag order of returned data is correct.
- rst pulsed low with 3 reads pending and the lock set -> FIFO empty, lock cleared, m_read=0 during reset, D favoured on release.
